// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around a combinational ALU with a 2**AW x WIDTH register file.
// Optional feature macro: ALU_STICKY_OVF_EN (sticky overflow flag with clear).
module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_ovf,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_waddr,
    input  logic [WIDTH-1:0] ext_wdata,
    input  logic [AW-1:0]    dbg_raddr,
    output logic [WIDTH-1:0] dbg_rdata,
    output logic             done,
    output logic [2:0]       flags,
    output logic             sticky_ovf,
    input  logic             clr_sticky
);

    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg, result_reg;
    logic [2:0]       alu_op_reg, cap_flags_reg, flags_reg;
    logic [AW-1:0]    rd_reg;
    logic             accept;
    logic             wb_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        wb_we       = 1'b0;
        instr_ready = 1'b0;
        done        = 1'b0;
        unique case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = WB;
            WB: begin
                done       = 1'b1;
                wb_we      = (rd_reg != '0);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Register file: r0 is hardwired to zero; writeback beats an external write to the same entry.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        if (gi == 0) begin : g_zero
            assign rf_q[gi] = '0;
        end else begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            logic [WIDTH-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (wb_we && rd_reg == IDX) begin
                    q_reg <= result_reg;
                end else if (ext_we && ext_waddr == IDX) begin
                    q_reg <= ext_wdata;
                end
            end
            assign rf_q[gi] = q_reg;
        end
    end

    assign dbg_rdata = rf_q[dbg_raddr];

    // Operands sample the pre-edge register contents, so a same-edge ext write is not bypassed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            rd_reg        <= '0;
            result_reg    <= '0;
            cap_flags_reg <= '0;
            flags_reg     <= '0;
        end else begin
            if (accept) begin
                alu_a_reg  <= rf_q[instr_rs1];
                alu_b_reg  <= rf_q[instr_rs2];
                alu_op_reg <= instr_op;
                rd_reg     <= instr_rd;
            end
            if (state_reg == EXEC) begin
                result_reg    <= alu_r;
                cap_flags_reg <= {alu_ovf, alu_zero, alu_carry};
            end
            if (state_reg == WB) begin
                flags_reg <= cap_flags_reg;
            end
        end
    end

    assign alu_a  = alu_a_reg;
    assign alu_b  = alu_b_reg;
    assign alu_op = alu_op_reg;
    assign flags  = flags_reg;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_ovf_reg;

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf_reg <= 1'b0;
        end else if (state_reg == WB && cap_flags_reg[2]) begin
            sticky_ovf_reg <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf_reg <= 1'b0;
        end
    end

    assign sticky_ovf = sticky_ovf_reg;
`else
    logic clr_sticky_unused;

    assign clr_sticky_unused = clr_sticky;
    assign sticky_ovf        = 1'b0;
`endif

endmodule
